l1_mem_arbiter: RTL and testbench
=================================

Name: l1_mem_arbiter

Overview:
Shares one external memory port between the L1 instruction cache miss interface and the L1 data cache miss/write-through interface. It accepts at most one transaction at a time. A winner is selected by fixed data priority with an instruction-starvation override. The arbiter latches the request, drives the memory handshake, and returns the response to the owner. It sits below icache/dcache inside top and replaces their direct memory connections.

Parameters:
STARVE_LIMIT, 4, consecutive contested grants lost by I before I is forced to win (legal range 1..15)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock
resetb  in  1  reset, active-low, synchronous
i_req  in  1  icache miss read request; held until i_wait is seen low
i_addr  in  AW  icache read address
i_rdata  out  DW  icache read data; valid in the cycle i_wait=0
i_wait  out  1  0 for exactly one cycle when the I transaction completes, else 1
d_req  in  1  dcache request; held until d_wait is seen low
d_write  in  1  1 = write, 0 = read
d_addr  in  AW  dcache address
d_wdata  in  DW  dcache write data
d_wstrb  in  4  dcache byte strobes (writes only)
d_rdata  out  DW  dcache read data; valid in the cycle d_wait=0
d_wait  out  1  0 for exactly one cycle when the D transaction completes, else 1
mem_req  out  1  memory request valid
mem_gnt  in  1  memory accepts the request (mem_req && mem_gnt = issued)
mem_write  out  1  memory write
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_wstrb  out  4  memory strobes; 4'b0000 on reads
mem_rvalid  in  1  memory response (read data or write ack), one cycle
mem_rdata  in  DW  memory read data, valid with mem_rvalid
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values (all registered): state=IDLE, owner=D, starve_cnt=0, mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, i_rdata=0, d_rdata=0, i_wait=1, d_wait=1, busy=0.
- FSM states:
  - IDLE: the winner is chosen from the requests sampled this cycle. If d_req only, D wins. If i_req only, I wins. If both, D wins unless starve_cnt >= STARVE_LIMIT, in which case I wins. On a win, latch owner, addr, write, wdata and wstrb, then go to REQ. An I request latches write=0 and wstrb=0. A D read forces wstrb=0.
  - REQ: mem_req=1 with the latched fields, held stable until mem_gnt. When mem_req && mem_gnt, go to RESP with mem_req=0 on the next cycle.
  - RESP: wait for mem_rvalid. On mem_rvalid, capture mem_rdata into the owner's rdata register (captured for D writes too) and go to DONE.
  - DONE: the owner's wait=0 for this one cycle, then go to IDLE. The other wait stays 1.
- Latency: with a zero-wait memory (mem_gnt=1, mem_rvalid the cycle after the grant), wait goes low 3 cycles after req is first sampled. Back-to-back transactions are spaced 4 cycles apart.
- starve_cnt (4-bit, saturating):
  - Increments when both requests are present in IDLE and D wins.
  - Clears whenever I wins.
  - Unchanged otherwise.
- The non-owner's request stays pending; it is never dropped or merged.
- mem_rvalid in IDLE, REQ or DONE is ignored (no state or data change).
- mem_gnt outside REQ is ignored.
- Protocol violation: if the owner drops req mid-transaction, the latched transaction still completes on memory. The wait pulse is still produced, and the result is discarded by the requester.
- Reset mid-operation: the next edge with resetb=0 returns everything to reset values. Any memory response outstanding at reset is ignored as an IDLE rvalid.
- A requester re-asserting req in the cycle after DONE is arbitrated normally in IDLE.

Test Plan:
1. I only: i_addr=0x0000_0100, memory returns 0xDEADBEEF one cycle after grant. Required: mem_addr=0x100, mem_write=0, mem_wstrb=0. i_wait is low for exactly one cycle, 3 cycles after i_req, with i_rdata=0xDEADBEEF. d_wait stays 1.
2. D write: d_addr=0x2000_0040, d_wdata=0x12345678, d_wstrb=4'b0011. mem_gnt is delayed 5 cycles. Required: mem_req and all fields held stable for 6 cycles; d_wait pulses once after mem_rvalid.
3. Contention with STARVE_LIMIT=4: both reqs held continuously and D re-requests immediately. Required grant order D,D,D,D,I,D,…, with starve_cnt reaching 4 then clearing to 0 on the I grant.
4. Stray response: mem_rvalid pulsed while in IDLE and in REQ. Required: no wait pulse, rdata registers unchanged, state unaffected.
5. Reset in RESP: resetb=0 for one edge during RESP, then the pending mem_rvalid arrives. Required: all outputs at reset values, mem_rvalid ignored, both waits remain 1.
6. Early drop: d_req deasserted during REQ. Required: transaction still issued and completed, and d_wait pulses once before returning to IDLE.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
`default_nettype none
// l1_mem_arbiter: one external memory port shared by L1 I-cache and D-cache misses.
// D has fixed priority; I is forced through after STARVE_LIMIT consecutive lost contests.
module l1_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_wait,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic [DW-1:0] d_rdata,
  output logic          d_wait,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic          owner_i_q, owner_i_d;
  logic [3:0]    starve_q, starve_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [DW-1:0] irdata_q, irdata_d;
  logic [DW-1:0] drdata_q, drdata_d;
  logic          mem_req_q, mem_req_d;
  logic          i_wait_q, i_wait_d;
  logic          d_wait_q, d_wait_d;
  logic          busy_q, busy_d;

  logic d_wins;
  logic i_wins;

  // I overrides D only once it has lost STARVE_LIMIT contested arbitrations in a row
  assign d_wins = d_req && !(i_req && (starve_q >= STARVE_LIM));
  assign i_wins = i_req && !d_wins;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (d_wins || i_wins) state_d = S_REQ;
      S_REQ:   if (mem_gnt) state_d = S_RESP;
      S_RESP:  if (mem_rvalid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with state_q
  always_comb begin
    mem_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
    i_wait_d  = !((state_d == S_DONE) && owner_i_d);
    d_wait_d  = !((state_d == S_DONE) && !owner_i_d);
  end

  always_comb begin
    owner_i_d = owner_i_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    irdata_d  = irdata_q;
    drdata_d  = drdata_q;
    if (state_q == S_IDLE) begin
      if (d_wins) begin
        owner_i_d = 1'b0;
        addr_d    = d_addr;
        write_d   = d_write;
        wdata_d   = d_wdata;
        wstrb_d   = d_write ? d_wstrb : 4'b0000;
        if (i_req && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
      end else if (i_wins) begin
        owner_i_d = 1'b1;
        addr_d    = i_addr;
        write_d   = 1'b0;
        wdata_d   = '0;
        wstrb_d   = 4'b0000;
        starve_d  = 4'd0;
      end
    end else if ((state_q == S_RESP) && mem_rvalid) begin
      if (owner_i_q) irdata_d = mem_rdata;
      else           drdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      owner_i_q <= 1'b0;
      starve_q  <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      irdata_q  <= '0;
      drdata_q  <= '0;
      mem_req_q <= 1'b0;
      i_wait_q  <= 1'b1;
      d_wait_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      owner_i_q <= owner_i_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      irdata_q  <= irdata_d;
      drdata_q  <= drdata_d;
      mem_req_q <= mem_req_d;
      i_wait_q  <= i_wait_d;
      d_wait_q  <= d_wait_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_write = write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign i_rdata   = irdata_q;
  assign d_rdata   = drdata_q;
  assign i_wait    = i_wait_q;
  assign d_wait    = d_wait_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_mem_arbiter.sv
`default_nettype none
// tb_l1_mem_arbiter: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level reference model built from arbitration timestamps.
module tb_l1_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_wait;
  logic          d_req = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic [DW-1:0] d_rdata;
  logic          d_wait;
  logic          mem_req;
  logic          mem_gnt = 1'b0;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetb(resetb),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_wait(i_wait),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_wait(d_wait),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction record stamped with the edge numbers of its win,
  // grant and response; outputs are derived from those stamps.
  int          cyc = 0;
  bit          m_active = 0;
  bit          m_owner_i = 0;
  int          m_starve = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_irdata = 0, m_drdata = 0;
  bit          m_write = 0;
  logic [3:0]  m_wstrb = 0;
  int          m_t_gnt = -1, m_t_rv = -1;

  task automatic model_edge();
    bit iw;
    cyc++;
    if (!resetb) begin
      m_active = 0; m_owner_i = 0; m_starve = 0; m_addr = 0; m_wdata = 0;
      m_write = 0; m_wstrb = 0; m_irdata = 0; m_drdata = 0; m_t_gnt = -1; m_t_rv = -1;
    end else if (!m_active) begin
      if (i_req || d_req) begin
        iw = i_req && (!d_req || m_starve >= STARVE_LIMIT);
        if (iw) m_starve = 0;
        else if (i_req) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        m_owner_i = iw;
        m_addr    = iw ? i_addr : d_addr;
        m_write   = iw ? 1'b0 : d_write;
        if (!iw) m_wdata = d_wdata;
        m_wstrb   = (!iw && d_write) ? d_wstrb : 4'b0000;
        m_active  = 1; m_t_gnt = -1; m_t_rv = -1;
      end
    end else if (m_t_gnt < 0) begin
      if (mem_gnt) m_t_gnt = cyc;
    end else if (m_t_rv < 0) begin
      if (mem_rvalid) begin
        m_t_rv = cyc;
        if (m_owner_i) m_irdata = mem_rdata;
        else           m_drdata = mem_rdata;
      end
    end else begin
      m_active = 0;
    end
  endtask

  task automatic check_outputs();
    check("busy", busy, m_active);
    check("mem_req", mem_req, m_active && m_t_gnt < 0);
    check("i_wait", i_wait, !(m_active && m_t_rv == cyc && m_owner_i));
    check("d_wait", d_wait, !(m_active && m_t_rv == cyc && !m_owner_i));
    check("mem_addr", mem_addr, m_addr);
    check("mem_write", mem_write, m_write);
    check("mem_wstrb", mem_wstrb, m_wstrb);
    if (m_write) check("mem_wdata", mem_wdata, m_wdata);
    check("i_rdata", i_rdata, m_irdata);
    check("d_rdata", d_rdata, m_drdata);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Memory agent: gnt_mode 0 random / 1 always / 2 never; rv_delay -1 random
  int          gnt_mode = 2;
  int          rv_delay = 0;
  int          rv_cnt = -1;
  bit          stray_en = 0;
  bit          force_rv = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_rdata = 0;
  int          hs_count = 0;

  task automatic mem_drive();
    if (force_rv) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000; force_rv = 0;
    end else if (rv_cnt == 0) begin
      mem_rvalid = 1'b1; mem_rdata = use_fixed ? fixed_rdata : $urandom; rv_cnt = -1;
    end else begin
      mem_rvalid = stray_en && rv_cnt < 0 && $urandom_range(0, 9) == 0;
      mem_rdata  = $urandom;
      if (rv_cnt > 0) rv_cnt--;
    end
    case (gnt_mode)
      0:       mem_gnt = $urandom_range(0, 2) != 0;
      1:       mem_gnt = 1'b1;
      default: mem_gnt = 1'b0;
    endcase
  endtask

  task automatic step();
    bit hs;
    mem_drive();
    hs = mem_req && mem_gnt;
    tick();
    if (hs) begin
      hs_count++;
      rv_cnt = (rv_delay < 0) ? int'($urandom_range(0, 3)) : rv_delay;
    end
  endtask

  task automatic req_drive();
    if (i_req && !i_wait) begin
      i_req = 1'($urandom_range(0, 1)); i_addr = $urandom;
    end else if (!i_req && $urandom_range(0, 2) == 0) begin
      i_req = 1'b1; i_addr = $urandom;
    end
    if (d_req && !d_wait) begin
      d_req = 1'($urandom_range(0, 1));
      d_write = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
    end else if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1'b1;
      d_write = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
    end
  endtask

  task automatic do_reset();
    resetb = 1'b0; i_req = 1'b0; d_req = 1'b0; rv_cnt = -1; force_rv = 0; gnt_mode = 2;
    step();
    step();
    resetb = 1'b1;
  endtask

  task automatic drain();
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 20 && busy; k++) step();
    check("drain idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int first_low, ilows, dlows, ngr, hs0;
    bit prev_req;
    logic [5:0] got_i, exp_i;

    // Reset values
    do_reset();
    check("rst busy", busy, 0);
    check("rst mem_req", mem_req, 0);
    check("rst i_wait", i_wait, 1);
    check("rst d_wait", d_wait, 1);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst mem_addr", mem_addr, 0);

    // I-only read with zero-wait memory
    use_fixed = 1; fixed_rdata = 32'hDEADBEEF; gnt_mode = 1; rv_delay = 0; stray_en = 0;
    i_req = 1'b1; i_addr = 32'h0000_0100;
    first_low = -1; ilows = 0; dlows = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        check("t1 mem_req", mem_req, 1);
        check("t1 mem_addr", mem_addr, 32'h100);
        check("t1 mem_write", mem_write, 0);
        check("t1 mem_wstrb", mem_wstrb, 0);
      end
      if (!i_wait) begin
        ilows++;
        if (first_low < 0) first_low = k;
        check("t1 i_rdata", i_rdata, 32'hDEADBEEF);
        i_req = 1'b0;
      end
      if (!d_wait) dlows++;
    end
    check("t1 i_wait cycle", first_low, 3);
    check("t1 i_wait pulses", ilows, 1);
    check("t1 d_wait pulses", dlows, 0);

    // D write with grant held off for five cycles
    do_reset();
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h2000_0040; d_wdata = 32'h1234_5678; d_wstrb = 4'b0011;
    gnt_mode = 2; rv_delay = 0; fixed_rdata = 32'h0000_00AC;
    step();
    for (int k = 1; k <= 6; k++) begin
      check("t2 mem_req held", mem_req, 1);
      check("t2 mem_addr held", mem_addr, 32'h2000_0040);
      check("t2 mem_wdata held", mem_wdata, 32'h1234_5678);
      check("t2 mem_wstrb held", mem_wstrb, 4'b0011);
      check("t2 mem_write held", mem_write, 1);
      gnt_mode = (k == 6) ? 1 : 2;
      step();
    end
    check("t2 mem_req dropped", mem_req, 0);
    dlows = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (!d_wait) begin dlows++; d_req = 1'b0; end
    end
    check("t2 d_wait pulses", dlows, 1);

    // Contention: both requesters hold continuously
    do_reset();
    gnt_mode = 1; rv_delay = 0;
    i_req = 1'b1; i_addr = 32'h0000_00A0;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_00B0;
    ngr = 0; prev_req = 0; got_i = '0; exp_i = 6'b010000;
    for (int k = 0; k < 40 && ngr < 6; k++) begin
      step();
      if (mem_req && !prev_req) begin
        got_i[ngr] = (mem_addr == 32'h0000_00A0);
        ngr++;
      end
      prev_req = mem_req;
    end
    check("t3 grant count", ngr, 6);
    for (int k = 0; k < 6; k++) check($sformatf("t3 grant%0d is_I", k), got_i[k], exp_i[k]);
    drain();

    // Stray responses in IDLE and REQ
    do_reset();
    use_fixed = 1; fixed_rdata = 32'h0BAD_F00D; rv_delay = 0; gnt_mode = 2;
    force_rv = 1;
    step();
    check("t4 idle busy", busy, 0);
    check("t4 idle i_wait", i_wait, 1);
    check("t4 idle d_wait", d_wait, 1);
    check("t4 idle i_rdata", i_rdata, 0);
    check("t4 idle d_rdata", d_rdata, 0);
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_3000;
    step();
    force_rv = 1;
    step();
    check("t4 req mem_req", mem_req, 1);
    check("t4 req d_wait", d_wait, 1);
    check("t4 req d_rdata", d_rdata, 0);
    gnt_mode = 1; dlows = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (!d_wait) begin
        dlows++; d_req = 1'b0;
        check("t4 d_rdata", d_rdata, 32'h0BAD_F00D);
      end
    end
    check("t4 d_wait pulses", dlows, 1);

    // Reset while waiting for the response
    do_reset();
    use_fixed = 1; fixed_rdata = 32'hCAFE_0001; gnt_mode = 1; rv_delay = 2;
    i_req = 1'b1; i_addr = 32'h0000_4000;
    step();
    step();
    check("t5 in resp busy", busy, 1);
    check("t5 in resp mem_req", mem_req, 0);
    resetb = 1'b0; i_req = 1'b0; gnt_mode = 2;
    step();
    resetb = 1'b1;
    check("t5 rst busy", busy, 0);
    check("t5 rst mem_req", mem_req, 0);
    check("t5 rst mem_addr", mem_addr, 0);
    check("t5 rst i_wait", i_wait, 1);
    check("t5 rst d_wait", d_wait, 1);
    ilows = 0; dlows = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!i_wait) ilows++;
      if (!d_wait) dlows++;
    end
    check("t5 i_wait pulses", ilows, 0);
    check("t5 d_wait pulses", dlows, 0);
    check("t5 i_rdata", i_rdata, 0);

    // Requester drops d_req while the request is pending
    do_reset();
    gnt_mode = 2; rv_delay = 1; fixed_rdata = 32'h7777_0006;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_5000;
    hs0 = hs_count;
    step();
    d_req = 1'b0;
    step();
    gnt_mode = 1; dlows = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!d_wait) dlows++;
    end
    check("t6 issued", hs_count - hs0, 1);
    check("t6 d_wait pulses", dlows, 1);
    check("t6 idle", busy, 0);

    // Randomized traffic
    do_reset();
    use_fixed = 0; gnt_mode = 0; rv_delay = -1; stray_en = 1;
    for (int k = 0; k < 3000; k++) begin
      req_drive();
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
